// File: rtl/cache_pkg.sv
// +--------------------------------------------------------------------+
// | cache_pkg : shared constants and FSM state type for the cache fill |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package cache_pkg;

   localparam int CACHE_ADDR_W = 15;
   localparam int CACHE_WORD_W = 32;
   localparam int CACHE_CNT_W  = 16;
   localparam int LINE_WORDS   = 4;

   localparam int TAG_HI    = 14;
   localparam int TAG_LO    = 12;
   localparam int INDEX_HI  = 11;
   localparam int INDEX_LO  = 2;
   localparam int OFFSET_HI = 1;
   localparam int OFFSET_LO = 0;
   localparam int OFFSET_W  = OFFSET_HI - OFFSET_LO + 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOOKUP  = 3'd1,
      FILL    = 3'd2,
      WRITE   = 3'd3,
      RESPOND = 3'd4
   } fill_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// +--------------------------------------------------------------------+
// | sat_counter : up-counter that sticks at all-ones                   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/cache_fill_controller.sv
// +--------------------------------------------------------------------+
// | cache_fill_controller : hit check, 4-beat line fill, hit/miss stats|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module cache_fill_controller
   import cache_pkg::*;
#(
   parameter int ADDR_W = CACHE_ADDR_W,
   parameter int WORD_W = CACHE_WORD_W,
   parameter int CNT_W  = CACHE_CNT_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_cpu_req,
   input  logic [ADDR_W-1:0]            i_cpu_addr,
   output logic                         o_cpu_ready,
   output logic [WORD_W-1:0]            o_cpu_data,
   output logic [ADDR_W-1:0]            o_cache_addr,
   output logic                         o_cache_read_en,
   input  logic                         i_cache_hit,
   input  logic [WORD_W-1:0]            i_cache_rdata,
   output logic                         o_cache_write_en,
   output logic [LINE_WORDS*WORD_W-1:0] o_cache_fill_data,
   output logic                         o_mem_req,
   output logic [ADDR_W-1:0]            o_mem_addr,
   input  logic                         i_mem_ack,
   input  logic [WORD_W-1:0]            i_mem_rdata,
   output logic [CNT_W-1:0]             o_hit_count,
   output logic [CNT_W-1:0]             o_miss_count
);

   localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(LINE_WORDS - 1);

   fill_state_t                         r_state;
   fill_state_t                         w_state_next;
   logic [ADDR_W-1:0]                   r_req_addr;
   logic [OFFSET_W-1:0]                 r_beat;
   logic [LINE_WORDS-1:0][WORD_W-1:0]   r_line_buf;
   logic [WORD_W-1:0]                   r_cpu_data;
   logic                                w_hit_inc;
   logic                                w_miss_inc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      o_cpu_ready      = 1'b0;
      o_cache_read_en  = 1'b0;
      o_cache_write_en = 1'b0;
      o_cache_addr     = '0;
      o_mem_req        = 1'b0;
      o_mem_addr       = '0;
      w_hit_inc        = 1'b0;
      w_miss_inc       = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_cpu_req) begin
               w_state_next = LOOKUP;
            end
         end
         LOOKUP: begin
            o_cache_read_en = 1'b1;
            o_cache_addr    = r_req_addr;
            if (i_cache_hit) begin
               w_hit_inc    = 1'b1;
               w_state_next = RESPOND;
            end else begin
               w_miss_inc   = 1'b1;
               w_state_next = FILL;
            end
         end
         FILL: begin
            // Whole line is fetched from word 0 upward, independent of the requested offset
            o_cache_addr = r_req_addr;
            o_mem_req    = 1'b1;
            o_mem_addr   = {r_req_addr[ADDR_W-1:OFFSET_W], r_beat};
            if (i_mem_ack && (r_beat == LAST_BEAT)) begin
               w_state_next = WRITE;
            end
         end
         WRITE: begin
            o_cache_addr     = r_req_addr;
            o_cache_write_en = 1'b1;
            w_state_next     = RESPOND;
         end
         RESPOND: begin
            o_cache_addr = r_req_addr;
            o_cpu_ready  = 1'b1;
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req_addr <= '0;
         r_beat     <= '0;
         r_line_buf <= '0;
         r_cpu_data <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_cpu_req) begin
                  r_req_addr <= i_cpu_addr;
               end
            end
            LOOKUP: begin
               if (i_cache_hit) begin
                  r_cpu_data <= i_cache_rdata;
               end else begin
                  r_beat <= '0;
               end
            end
            FILL: begin
               if (i_mem_ack) begin
                  r_line_buf[r_beat] <= i_mem_rdata;
                  r_beat             <= r_beat + OFFSET_W'(1);
               end
            end
            WRITE: begin
               r_cpu_data <= r_line_buf[r_req_addr[OFFSET_HI:OFFSET_LO]];
            end
            default: begin
            end
         endcase
      end
   end

   assign o_cpu_data        = r_cpu_data;
   assign o_cache_fill_data = r_line_buf;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_hit_counter (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_hit_inc),
      .o_count (o_hit_count)
   );

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_miss_counter (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_miss_inc),
      .o_count (o_miss_count)
   );

endmodule

`default_nettype wire

// File: tb/tb_cache_fill_controller.sv
// +--------------------------------------------------------------------+
// | tb_cache_fill_controller : directed self-checking bench            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_cache_fill_controller;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_cpu_req;
   logic [14:0]   i_cpu_addr;
   logic          o_cpu_ready;
   logic [31:0]   o_cpu_data;
   logic [14:0]   o_cache_addr;
   logic          o_cache_read_en;
   logic          i_cache_hit;
   logic [31:0]   i_cache_rdata;
   logic          o_cache_write_en;
   logic [127:0]  o_cache_fill_data;
   logic          o_mem_req;
   logic [14:0]   o_mem_addr;
   logic          i_mem_ack;
   logic [31:0]   i_mem_rdata;
   logic [15:0]   o_hit_count;
   logic [15:0]   o_miss_count;
   logic          sat_inc;
   logic [3:0]    sat_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cache_fill_controller #(
      .ADDR_W (15),
      .WORD_W (32),
      .CNT_W  (16)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .i_cpu_req         (i_cpu_req),
      .i_cpu_addr        (i_cpu_addr),
      .o_cpu_ready       (o_cpu_ready),
      .o_cpu_data        (o_cpu_data),
      .o_cache_addr      (o_cache_addr),
      .o_cache_read_en   (o_cache_read_en),
      .i_cache_hit       (i_cache_hit),
      .i_cache_rdata     (i_cache_rdata),
      .o_cache_write_en  (o_cache_write_en),
      .o_cache_fill_data (o_cache_fill_data),
      .o_mem_req         (o_mem_req),
      .o_mem_addr        (o_mem_addr),
      .i_mem_ack         (i_mem_ack),
      .i_mem_rdata       (i_mem_rdata),
      .o_hit_count       (o_hit_count),
      .o_miss_count      (o_miss_count)
   );

   // Narrow instance so saturation is reachable in a few cycles
   sat_counter #(
      .CNT_W (4)
   ) u_sat (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (sat_inc),
      .o_count (sat_count)
   );

   function automatic logic [31:0] mem_word(input logic [14:0] a);
      return 32'hC0DE_0000 | {17'b0, a};
   endfunction

   // Cache array model plus bus monitors
   logic [1023:0] c_valid;
   logic [2:0]    c_tag  [0:1023];
   logic [127:0]  c_line [0:1023];
   logic [9:0]    w_idx;
   logic [127:0]  w_line;
   logic [14:0]   ack_addrs [$];
   int            wr_cnt = 0;
   logic [127:0]  wr_line = '0;
   int            stab_viol = 0;
   int            both_viol = 0;
   logic          prev_pending = 1'b0;
   logic [14:0]   prev_addr = '0;

   assign w_idx         = o_cache_addr[11:2];
   assign w_line        = c_line[w_idx];
   assign i_cache_hit   = c_valid[w_idx] && (c_tag[w_idx] == o_cache_addr[14:12]);
   assign i_cache_rdata = w_line[{o_cache_addr[1:0], 5'b0} +: 32];

   always @(posedge clk) begin
      if (rst) begin
         c_valid <= '0;
      end else begin
         if (o_cache_write_en) begin
            c_valid[w_idx] <= 1'b1;
            c_tag[w_idx]   <= o_cache_addr[14:12];
            c_line[w_idx]  <= o_cache_fill_data;
            wr_cnt         <= wr_cnt + 1;
            wr_line        <= o_cache_fill_data;
         end
         if (i_mem_ack && o_mem_req) ack_addrs.push_back(o_mem_addr);
         if (prev_pending && o_mem_req && (o_mem_addr != prev_addr)) stab_viol <= stab_viol + 1;
         if (o_cache_read_en && o_cache_write_en) both_viol <= both_viol + 1;
      end
      prev_pending <= o_mem_req && !i_mem_ack;
      prev_addr    <= o_mem_addr;
   end

   // Memory responder: ack gap drawn from 0..gap_max after each beat
   int   gap_max = 0;
   int   gap = 0;
   logic force_ack = 1'b0;

   initial begin
      i_mem_ack   = 1'b0;
      i_mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (force_ack) begin
            i_mem_ack   = 1'b1;
            i_mem_rdata = 32'hDEAD_BEEF;
         end else if (o_mem_req) begin
            if (gap == 0) begin
               i_mem_ack   = 1'b1;
               i_mem_rdata = mem_word(o_mem_addr);
               gap = (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
            end else begin
               i_mem_ack = 1'b0;
               gap = gap - 1;
            end
         end else begin
            i_mem_ack = 1'b0;
         end
      end
   end

   task automatic do_load(input logic [14:0] a, input bit toggle,
                          output int lat, output logic [31:0] data);
      lat = 0;
      @(negedge clk);
      i_cpu_req  = 1'b1;
      i_cpu_addr = a;
      while (lat < 200) begin
         @(negedge clk);
         lat++;
         if (o_cpu_ready) begin
            i_cpu_req = 1'b0;
            break;
         end
         i_cpu_req  = toggle && (lat % 2 == 1);
         i_cpu_addr = toggle ? 15'h7FFF : a;
      end
      i_cpu_req = 1'b0;
      data = o_cpu_data;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (o_cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_cpu_ready got %0b exp 0", o_cpu_ready); end
      checks++; if (o_cpu_data !== 32'h0) begin errors++; $display("FAIL reset_cpu_data got %h exp 0", o_cpu_data); end
      checks++; if (o_cache_addr !== 15'h0) begin errors++; $display("FAIL reset_cache_addr got %h exp 0", o_cache_addr); end
      checks++; if ({o_cache_read_en, o_cache_write_en, o_mem_req} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b exp 000", {o_cache_read_en, o_cache_write_en, o_mem_req}); end
      checks++; if (o_mem_addr !== 15'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", o_mem_addr); end
      checks++; if (o_cache_fill_data !== 128'h0) begin errors++; $display("FAIL reset_fill_data got %h exp 0", o_cache_fill_data); end
      checks++; if ({o_hit_count, o_miss_count} !== 32'h0) begin errors++; $display("FAIL reset_counters got %h/%h exp 0/0", o_hit_count, o_miss_count); end
      rst = 1'b0;
   endtask

   task automatic test_miss_fill();
      int lat; logic [31:0] d; int base; int w0; logic [14:0] ea; logic [31:0] held;
      base = ack_addrs.size(); w0 = wr_cnt;
      do_load(15'h1234, 1'b0, lat, d);
      checks++; if (lat != 7) begin errors++; $display("FAIL miss_latency got %0d exp 7", lat); end
      checks++; if (d !== 32'hC0DE1234) begin errors++; $display("FAIL miss_data got %h exp C0DE1234", d); end
      checks++; if (o_miss_count !== 16'd1 || o_hit_count !== 16'd0) begin errors++; $display("FAIL miss_counts got h%0d m%0d exp h0 m1", o_hit_count, o_miss_count); end
      checks++; if (wr_cnt != w0 + 1) begin errors++; $display("FAIL miss_write_count got %0d exp %0d", wr_cnt, w0 + 1); end
      checks++; if (ack_addrs.size() != base + 4) begin errors++; $display("FAIL miss_ack_count got %0d exp %0d", ack_addrs.size() - base, 4); end
      for (int i = 0; i < 4 && base + i < ack_addrs.size(); i++) begin
         ea = 15'h1234 + 15'(i);
         checks++; if (ack_addrs[base + i] !== ea) begin errors++; $display("FAIL miss_mem_addr beat %0d got %h exp %h", i, ack_addrs[base + i], ea); end
      end
      checks++; if (wr_line !== {32'hC0DE1237, 32'hC0DE1236, 32'hC0DE1235, 32'hC0DE1234}) begin errors++; $display("FAIL miss_fill_line got %h", wr_line); end
      held = o_cpu_data;
      repeat (2) @(negedge clk);
      checks++; if (o_cpu_data !== 32'hC0DE1234 || o_cpu_ready !== 1'b0) begin errors++; $display("FAIL data_hold got %h rdy %0b exp C0DE1234 rdy 0 (was %h)", o_cpu_data, o_cpu_ready, held); end
   endtask

   task automatic test_hit();
      int lat; logic [31:0] d; int base;
      base = ack_addrs.size();
      do_load(15'h1235, 1'b0, lat, d);
      checks++; if (lat != 2) begin errors++; $display("FAIL hit_latency got %0d exp 2", lat); end
      checks++; if (d !== 32'hC0DE1235) begin errors++; $display("FAIL hit_data got %h exp C0DE1235", d); end
      checks++; if (o_hit_count !== 16'd1 || o_miss_count !== 16'd1) begin errors++; $display("FAIL hit_counts got h%0d m%0d exp h1 m1", o_hit_count, o_miss_count); end
      checks++; if (ack_addrs.size() != base) begin errors++; $display("FAIL hit_no_mem got %0d acks exp 0", ack_addrs.size() - base); end
   endtask

   task automatic test_tag_conflict();
      int lat; logic [31:0] d; int w0;
      w0 = wr_cnt;
      do_load(15'h5234, 1'b0, lat, d);
      checks++; if (lat != 7 || d !== 32'hC0DE5234) begin errors++; $display("FAIL conflict_miss got lat %0d data %h exp 7 C0DE5234", lat, d); end
      checks++; if (wr_line[31:0] !== 32'hC0DE5234 || wr_cnt != w0 + 1) begin errors++; $display("FAIL conflict_refill got %h wr %0d exp C0DE5234 wr %0d", wr_line[31:0], wr_cnt, w0 + 1); end
      do_load(15'h1236, 1'b0, lat, d);
      checks++; if (lat != 7 || d !== 32'hC0DE1236) begin errors++; $display("FAIL conflict_remiss got lat %0d data %h exp 7 C0DE1236", lat, d); end
      checks++; if (o_miss_count !== 16'd3 || o_hit_count !== 16'd1) begin errors++; $display("FAIL conflict_counts got h%0d m%0d exp h1 m3", o_hit_count, o_miss_count); end
   endtask

   task automatic test_ack_gaps();
      int lat; logic [31:0] d; int base; logic [14:0] ea;
      base = ack_addrs.size();
      gap_max = 5;
      do_load(15'h0A7E, 1'b0, lat, d);
      gap_max = 0;
      checks++; if (d !== 32'hC0DE0A7E || lat < 7 || lat >= 200) begin errors++; $display("FAIL gaps_data got %h lat %0d exp C0DE0A7E lat>=7", d, lat); end
      checks++; if (stab_viol != 0) begin errors++; $display("FAIL gaps_addr_stable got %0d changes exp 0", stab_viol); end
      for (int i = 0; i < 4 && base + i < ack_addrs.size(); i++) begin
         ea = 15'h0A7C + 15'(i);
         checks++; if (ack_addrs[base + i] !== ea) begin errors++; $display("FAIL gaps_order beat %0d got %h exp %h", i, ack_addrs[base + i], ea); end
      end
      checks++; if (wr_line[127:96] !== 32'hC0DE0A7F) begin errors++; $display("FAIL gaps_word3 got %h exp C0DE0A7F", wr_line[127:96]); end
   endtask

   task automatic test_reset_mid_fill();
      int lat; logic [31:0] d; int base; int w0; int cyc;
      base = ack_addrs.size(); w0 = wr_cnt; cyc = 0;
      @(negedge clk);
      i_cpu_req  = 1'b1;
      i_cpu_addr = 15'h2468;
      while (ack_addrs.size() < base + 2 && cyc < 100) begin
         @(negedge clk);
         i_cpu_req = 1'b0;
         cyc++;
      end
      checks++; if (cyc >= 100) begin errors++; $display("FAIL midfill_timeout got %0d acks exp 2", ack_addrs.size() - base); end
      rst = 1'b1;
      #1;
      checks++; if (o_mem_req !== 1'b0 || o_cache_write_en !== 1'b0) begin errors++; $display("FAIL midfill_req_drop got req %0b wr %0b exp 0 0", o_mem_req, o_cache_write_en); end
      checks++; if (o_hit_count !== 16'd0 || o_miss_count !== 16'd0) begin errors++; $display("FAIL midfill_counters got h%0d m%0d exp 0 0", o_hit_count, o_miss_count); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (wr_cnt != w0) begin errors++; $display("FAIL midfill_no_write got %0d exp %0d", wr_cnt, w0); end
      do_load(15'h2468, 1'b0, lat, d);
      checks++; if (lat != 7 || d !== 32'hC0DE2468) begin errors++; $display("FAIL midfill_refill got lat %0d data %h exp 7 C0DE2468", lat, d); end
      checks++; if (o_miss_count !== 16'd1 || wr_cnt != w0 + 1) begin errors++; $display("FAIL midfill_refill_stats got m%0d wr %0d exp m1 wr %0d", o_miss_count, wr_cnt, w0 + 1); end
   endtask

   task automatic test_ignored_inputs();
      int lat; logic [31:0] d; int base; int w0;
      gap_max = 2;
      do_load(15'h3001, 1'b1, lat, d);
      gap_max = 0;
      checks++; if (d !== 32'hC0DE3001 || lat >= 200) begin errors++; $display("FAIL toggle_data got %h lat %0d exp C0DE3001", d, lat); end
      checks++; if (o_miss_count !== 16'd2 || o_hit_count !== 16'd0) begin errors++; $display("FAIL toggle_counts got h%0d m%0d exp h0 m2", o_hit_count, o_miss_count); end
      @(negedge clk);
      base = ack_addrs.size(); w0 = wr_cnt;
      force_ack = 1'b1;
      repeat (3) @(negedge clk);
      force_ack = 1'b0;
      @(negedge clk);
      checks++; if (o_mem_req !== 1'b0 || o_cache_read_en !== 1'b0 || wr_cnt != w0 || ack_addrs.size() != base) begin errors++; $display("FAIL spurious_ack got req %0b rd %0b wr %0d exp 0 0 %0d", o_mem_req, o_cache_read_en, wr_cnt, w0); end
      checks++; if (o_miss_count !== 16'd2 || o_hit_count !== 16'd0) begin errors++; $display("FAIL spurious_counts got h%0d m%0d exp h0 m2", o_hit_count, o_miss_count); end
   endtask

   task automatic test_back_to_back();
      int lat; logic [31:0] d; logic [31:0] e;
      for (int i = 0; i < 3; i++) begin
         do_load(15'h3000 + 15'(i), 1'b0, lat, d);
         e = 32'hC0DE3000 + i;
         checks++; if (d !== e || lat != 2) begin errors++; $display("FAIL b2b_hit %0d got %h lat %0d exp %h lat 2", i, d, lat, e); end
      end
      checks++; if (o_hit_count !== 16'd3) begin errors++; $display("FAIL b2b_hit_count got %0d exp 3", o_hit_count); end
      checks++; if (both_viol != 0) begin errors++; $display("FAIL rd_wr_overlap got %0d exp 0", both_viol); end
   endtask

   task automatic test_saturation();
      @(negedge clk);
      sat_inc = 1'b1;
      repeat (14) @(negedge clk);
      checks++; if (sat_count !== 4'd14) begin errors++; $display("FAIL sat_count_14 got %0d exp 14", sat_count); end
      repeat (6) @(negedge clk);
      checks++; if (sat_count !== 4'hF) begin errors++; $display("FAIL sat_count_hold got %0d exp 15", sat_count); end
      sat_inc = 1'b0;
   endtask

   initial begin
      i_cpu_req  = 1'b0;
      i_cpu_addr = '0;
      sat_inc    = 1'b0;
      test_reset();
      test_miss_fill();
      test_hit();
      test_tag_conflict();
      test_ack_gaps();
      test_reset_mid_fill();
      test_ignored_inputs();
      test_back_to_back();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
